// File: rtl/lamp_ctrl_n.sv
// Multi-switch lamp controller: N_SW synchronised, debounced switches each toggle one lamp,
// with an optional auto-off timer and a synchronous force-off; all outputs are registered.
module lamp_ctrl_n #(
  parameter int N_SW    = 3,
  parameter int DB_MAX  = 4,
  parameter int DB_W    = 3,
  parameter int TIMEOUT = 0,
  parameter int TO_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw,
  input  logic            all_off,
  output logic            F,
  output logic [N_SW-1:0] sw_db,
  output logic            toggle,
  output logic            timeout
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_MAX - 1);
  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_EN ? TIMEOUT - 1 : 0);

  logic [N_SW-1:0]           s1_q, s2_q;
  logic [N_SW-1:0]           sw_db_q, sw_db_d;
  logic [N_SW-1:0][DB_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]           timer_q, timer_d;
  logic                      f_q, f_d;
  logic                      toggle_q, toggle_d;
  logic                      timeout_q, timeout_d;
  logic [N_SW-1:0]           flip;
  logic                      par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      sw_db_q   <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      f_q       <= 1'b0;
      toggle_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      s1_q      <= sw;
      s2_q      <= s1_q;
      sw_db_q   <= sw_db_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      f_q       <= f_d;
      toggle_q  <= toggle_d;
      timeout_q <= timeout_d;
    end
  end

  // A channel is accepted only after DB_MAX consecutive samples disagree with its settled level.
  always_comb begin
    sw_db_d = sw_db_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < N_SW; i++) begin
      if (s2_q[i] == sw_db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        sw_db_d[i] = s2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign flip = sw_db_d ^ sw_db_q;
  assign par  = ^flip;

  // Even-parity flip cycles fall through to the timer branch, so they do not restart it.
  always_comb begin
    f_d       = f_q;
    toggle_d  = 1'b0;
    timeout_d = 1'b0;
    timer_d   = '0;
    if (all_off) begin
      f_d = 1'b0;
    end else if (par) begin
      f_d      = ~f_q;
      toggle_d = 1'b1;
    end else if (TO_EN && f_q && (timer_q == TO_LAST)) begin
      f_d       = 1'b0;
      timeout_d = 1'b1;
    end else if (TO_EN && f_q) begin
      timer_d = timer_q + 1'b1;
    end
  end

  assign F       = f_q;
  assign sw_db   = sw_db_q;
  assign toggle  = toggle_q;
  assign timeout = timeout_q;

endmodule
